// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Contents: frame FSM state enum, frame constants, baud divisor helper.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state for 8E1 frames).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CNT_W     = 16;

  // Frame FSM states; PARITY only exists when even parity is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  // Rounded clock cycles per bit for a given clock and baud rate.
  function automatic int unsigned default_clks_per_bit(input int unsigned clk_hz,
                                                       input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead FIFO: head is always presented on 'head' with 'valid' while non-empty.
// Ports:
//   CLK, RST_N     clock, async active-low reset
//   push/push_data write request and data
//   pop_ready      consumer accepts head this cycle (pop = valid & pop_ready)
//   valid, head    registered non-empty flag and head entry
//   drop_c         push rejected because full with no simultaneous pop
module rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_c, full_c, wr_en_c, valid_d;
  logic [WIDTH-1:0] head_d;

  assign pop_c   = valid & pop_ready;
  assign full_c  = (count_q == CW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_c = push & (~full_c | pop_c);
  assign drop_c  = push & full_c & ~pop_c;

  assign rd_ptr_d = rd_ptr_q + AW'(pop_c);
  assign wr_ptr_d = wr_ptr_q + AW'(wr_en_c);
  assign count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);

  // Valid follows the post-pop occupancy; a fresh push shows up one cycle later.
  assign valid_d = (count_q != CW'(pop_c));
  // Bypass when the entry being written becomes the new head.
  assign head_d  = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];

  // Pointers, occupancy and registered head view.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid    <= 1'b0;
      head     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid    <= valid_d;
      head     <= head_d;
    end
  end

  // Storage array.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises 'rx', frames bytes by mid-bit sampling and queues
// them in a show-ahead FIFO for the core.
// Ports:
//   CLK, RST_N           clock, async active-low reset
//   rx                   serial line (idle high, asynchronous)
//   rd_ready             core accepts head byte
//   rd_valid, rd_data    FIFO non-empty flag and head byte
//   err                  sticky: frame error, overflow (and parity error if enabled)
//   err_clr              clears err; a same-cycle new error wins
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames, parity errors drop the byte).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = default_clks_per_bit(100_000_000, 115_200),
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 rx,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 err,
  input  logic                 err_clr
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam int unsigned      BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_prev_q, rx_s, fall_c;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tick_c, push_c, frame_err_c, drop_c, err_set_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d, par_err_c;
`endif

  // Two-flop synchroniser plus edge history; resets to idle-high so no false start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= sync_q[1];
    end
  end

  assign rx_s   = sync_q[1];
  // Only a falling edge starts a frame, so a held-low break cannot retrigger.
  assign fall_c = rx_prev_q & ~rx_s;
  assign tick_c = (cnt_q == '0);

  // Frame FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Frame FSM next-state and sample strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    push_c      = 1'b0;
    frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_c   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (!tick_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          cnt_d   = FULL_LOAD;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (!tick_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!tick_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          par_bad_d = (^shreg_q) ^ rx_s;
          cnt_d     = FULL_LOAD;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (!tick_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          if (!rx_s) begin
            frame_err_c = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            par_err_c = 1'b1;
`endif
          end else begin
            push_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign err_set_c = frame_err_c | drop_c | par_err_c;
`else
  assign err_set_c = frame_err_c | drop_c;
`endif

  // Sticky error flag; a new error outranks a clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err <= 1'b0;
    end else if (err_set_c) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push_c),
    .push_data (shreg_q),
    .pop_ready (rd_ready),
    .valid     (rd_valid),
    .head      (rd_data),
    .drop_c    (drop_c)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven serially, accepted bytes are
// queued as expectations and compared whenever the core side pops one.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Clock edge (counted from the edge after the start bit is driven) on which the
  // stop-bit sample pushes into the FIFO.
  localparam int PUSH_EDGE = 3 + CPB / 2 + (9 + PB) * CPB;

  logic       clk, rst_n, rx, rd_ready, err_clr;
  logic       rd_valid, err;
  logic [7:0] rd_data;

  logic [7:0] sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         lat;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .rx       (rx),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .err      (err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      check("pop_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("rd_data", 32'(rd_data), 32'(sb.pop_front()));
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PB == 1) drive_bit(par_bit);
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_frame(d, stop_bit, ^d);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rd_ready = v;
  endtask

  task automatic clear_err();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_after_clr", 32'(err), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || rd_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rx = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame: latency, data, single-cycle valid with rd_ready held high.
    set_ready(1'b1);
    sb.push_back(8'h55);
    fork
      send_byte(8'h55, 1'b1);
      begin
        lat = 0;
        @(negedge clk);
        while (!rd_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
        check("latency", 32'(lat), 32'(PUSH_EDGE + 1));
        check("err_clean", 32'(err), 32'd0);
        @(negedge clk);
        check("valid_fall", 32'(rd_valid), 32'd0);
      end
    join
    wait_drain("drain_55");

    // Glitch shorter than half a bit is a false start.
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", 32'(rd_valid), 32'd0);
    check("glitch_err", 32'(err), 32'd0);
    sb.push_back(8'hA3);
    send_byte(8'hA3, 1'b1);
    wait_drain("drain_a3");

    // Framing error drops the byte and sets err.
    send_byte(8'h3C, 1'b0);
    check("frame_err", 32'(err), 32'd1);
    check("frame_drop", 32'(rd_valid), 32'd0);
    clear_err();
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_drain("drain_81");

    // Overflow: fifth byte dropped, first four kept in order.
    set_ready(1'b0);
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) sb.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_valid", 32'(rd_valid), 32'd1);
    set_ready(1'b1);
    wait_drain("drain_ovf");
    check("ovf_empty", 32'(rd_valid), 32'd0);
    clear_err();

    // Full FIFO with a pop on the push cycle: push accepted, no error.
    set_ready(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(8'(8'h11 + i));
      send_byte(8'(8'h11 + i), 1'b1);
    end
    sb.push_back(8'h15);
    fork
      send_byte(8'h15, 1'b1);
      begin
        @(negedge clk);
        repeat (PUSH_EDGE - 1) @(posedge clk);
        #1 rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
      end
    join
    check("full_pop_err", 32'(err), 32'd0);
    check("full_pop_count", 32'(sb.size()), 32'(DEPTH));
    set_ready(1'b1);
    wait_drain("drain_full_pop");

    // Asynchronous reset mid-frame with queued bytes and err set.
    set_ready(1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    check("pre_rst_err", 32'(err), 32'd1);
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rd_valid), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("post_rst_valid", 32'(rd_valid), 32'd0);
    set_ready(1'b1);
    sb.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    wait_drain("drain_7e");
    check("post_rst_err", 32'(err), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1.
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_err", 32'(err), 32'd1);
    check("par_drop", 32'(rd_valid), 32'd0);
    clear_err();
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain("drain_par");
    check("par_ok_err", 32'(err), 32'd0);
`endif

    repeat (10) @(negedge clk);
    check("sb_final", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
